// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  // Fixed writeback source slots on the arbiter
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LSU = 1;
  localparam int unsigned SRC_MDU = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last grantee (i_ptr).
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  // Two ascending passes: indices above the pointer first, then wrap around
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!o_grant_valid && i_req[i] && (i > 32'(i_ptr))) begin
        o_grant[i]    = 1'b1;
        o_grant_idx   = IW'(i);
        o_grant_valid = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!o_grant_valid && i_req[i] && (i <= 32'(i_ptr))) begin
        o_grant[i]    = 1'b1;
        o_grant_idx   = IW'(i);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates writeback sources onto the single register
// file write port and tracks pending destinations to stall hazardous issues.
module regfile_wb_scheduler #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic [REG_AW-1:0]        issue_rs1,
  input  logic [REG_AW-1:0]        issue_rs2,
  output logic                     issue_stall,
  input  logic [NUM_SRC-1:0]       wb_valid,
  input  logic [NUM_SRC*REG_AW-1:0] wb_rd,
  input  logic [NUM_SRC*XLEN-1:0]  wb_data,
  output logic [NUM_SRC-1:0]       wb_ready,
  output logic [REG_AW-1:0]        rf_a3,
  output logic [XLEN-1:0]          rf_wd,
  output logic                     rf_wen,
  output logic [31:0]              pending
);

  import regfile_wb_scheduler_pkg::*;

  localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]       r_rr_ptr;
  logic [NUM_SRC-1:0]  w_grant;
  logic [PW-1:0]       w_gidx;
  logic                w_gvalid;
  logic [REG_AW-1:0]   w_sel_rd;
  logic [XLEN-1:0]     w_sel_data;
  logic                w_sel_wr;
  logic [REG_AW-1:0]   r_a3;
  logic [XLEN-1:0]     r_wd;
  logic                r_wen;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_issue_set;

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (PW)
  ) u_arb (
    .i_req         (wb_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_gidx),
    .o_grant_valid (w_gvalid)
  );

  assign wb_ready = w_grant;

  // Select the granted source's destination and data
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = wb_rd[i*REG_AW +: REG_AW];
        w_sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writebacks are consumed but never reach the register file
  assign w_sel_wr = w_gvalid && (w_sel_rd != '0);

  // Round-robin pointer remembers the last grantee; holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= PW'(NUM_SRC - 1);
    end else if (w_gvalid) begin
      r_rr_ptr <= w_gidx;
    end
  end

  // Write stage: one-cycle registered path to the register file port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
    end else begin
      r_wen <= w_sel_wr;
      if (w_sel_wr) begin
        r_a3 <= w_sel_rd;
        r_wd <= w_sel_data;
      end
    end
  end

  assign rf_wen = r_wen;
  assign rf_a3  = r_a3;
  assign rf_wd  = r_wd;

  // Stall when any named register still has a write outstanding
  assign issue_stall = issue_valid &&
                       (r_pending[issue_rs1] || r_pending[issue_rs2] || r_pending[issue_rd]);
  assign w_issue_set = issue_valid && !issue_stall && (issue_rd != '0);

  // Next scoreboard: commit clears first, so a same-index issue set wins
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_wen && (r_a3 != '0)) begin
      w_pend_nxt[r_a3] = 1'b0;
    end
    if (w_issue_set) begin
      w_pend_nxt[issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus
// randomized issue/writeback traffic against a behavioural model.
module tb_regfile_wb_scheduler;

  import regfile_wb_scheduler_pkg::*;

  localparam int NUM_SRC = 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      issue_valid = 1'b0;
  logic [REG_AW-1:0]         issue_rd = '0;
  logic [REG_AW-1:0]         issue_rs1 = '0;
  logic [REG_AW-1:0]         issue_rs2 = '0;
  logic                      issue_stall;
  logic [NUM_SRC-1:0]        wb_valid = '0;
  logic [NUM_SRC*REG_AW-1:0] wb_rd = '0;
  logic [NUM_SRC*XLEN-1:0]   wb_data = '0;
  logic [NUM_SRC-1:0]        wb_ready;
  logic [REG_AW-1:0]         rf_a3;
  logic [XLEN-1:0]           rf_wd;
  logic                      rf_wen;
  logic [31:0]               pending;

  int n_checks = 0;
  int n_err    = 0;

  regfile_wb_scheduler #(
    .NUM_SRC (NUM_SRC),
    .XLEN    (XLEN),
    .REG_AW  (REG_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rf_a3       (rf_a3),
    .rf_wd       (rf_wd),
    .rf_wen      (rf_wen),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]       m_pend = '0;
  int                m_last = NUM_SRC - 1;
  logic              m_wen  = 1'b0;
  logic [REG_AW-1:0] m_a3   = '0;
  logic [XLEN-1:0]   m_wd   = '0;

  wb_req_t srcq [NUM_SRC][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner = first requester after the last grantee, wrapping around
  function automatic int exp_grant(input logic [NUM_SRC-1:0] v, input int last);
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (last + k) % NUM_SRC;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic exp_stall(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] p);
    return v && (p[rs1] || p[rs2] || p[rd]);
  endfunction

  function automatic logic [31:0] next_pend(input logic [31:0] p, input logic wen,
                                            input logic [4:0] a3, input logic fire,
                                            input logic [4:0] rd);
    logic [31:0] q;
    q = p;
    if (wen && a3 != 0) q[a3] = 1'b0;
    if (fire && rd != 0) q[rd] = 1'b1;
    return q;
  endfunction

  function automatic logic [REG_AW-1:0] src_rd(input int s);
    return wb_rd[s*REG_AW +: REG_AW];
  endfunction

  function automatic logic [XLEN-1:0] src_data(input int s);
    return wb_data[s*XLEN +: XLEN];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0;
      m_last <= NUM_SRC - 1;
      m_wen  <= 1'b0;
      m_a3   <= '0;
      m_wd   <= '0;
    end else begin
      m_pend <= next_pend(m_pend, m_wen, m_a3,
                          issue_valid && !exp_stall(issue_valid, issue_rd, issue_rs1, issue_rs2, m_pend),
                          issue_rd);
      if (exp_grant(wb_valid, m_last) >= 0) begin
        m_last <= exp_grant(wb_valid, m_last);
        m_wen  <= (src_rd(exp_grant(wb_valid, m_last)) != 0);
        if (src_rd(exp_grant(wb_valid, m_last)) != 0) begin
          m_a3 <= src_rd(exp_grant(wb_valid, m_last));
          m_wd <= src_data(exp_grant(wb_valid, m_last));
        end
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int   g;
    logic coll;
    g = exp_grant(wb_valid, m_last);
    check("wb_ready", 32'(wb_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("issue_stall", 32'(issue_stall), 32'(exp_stall(issue_valid, issue_rd, issue_rs1, issue_rs2, m_pend)));
    check("rf_wen", 32'(rf_wen), 32'(m_wen));
    if (m_wen) begin
      check("rf_a3", 32'(rf_a3), 32'(m_a3));
      check("rf_wd", rf_wd, m_wd);
    end
    check("pending", pending, m_pend);
    if (rst_n) begin
      coll = issue_valid && !exp_stall(issue_valid, issue_rd, issue_rs1, issue_rs2, m_pend) &&
             (issue_rd != 0) && m_wen && (m_a3 == issue_rd);
      check("set_clear_collision", 32'(coll), 32'd0);
      if (g >= 0 && src_rd(g) != 0 && !m_pend[src_rd(g)])
        $display("note: writeback to non-pending x%0d from source %0d", src_rd(g), g);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  task automatic set_wb(input int s, input logic [4:0] rd, input logic [31:0] d);
    wb_valid[s]               = 1'b1;
    wb_rd[s*REG_AW +: REG_AW] = rd;
    wb_data[s*XLEN +: XLEN]   = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_issue(1'b0, '0, '0, '0);
    wb_valid = '0;
    for (int s = 0; s < NUM_SRC; s++) srcq[s].delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_cycle(input bit allow_issue);
    int      g;
    bit      fired;
    wb_req_t e;
    @(negedge clk);
    g     = exp_grant(wb_valid, m_last);
    fired = issue_valid && !exp_stall(issue_valid, issue_rd, issue_rs1, issue_rs2, m_pend);
    @(posedge clk);
    #1;
    if (fired && issue_rd != 0) begin
      e.rd   = issue_rd;
      e.data = $urandom;
      srcq[$urandom_range(0, NUM_SRC-1)].push_back(e);
    end
    if (allow_issue && $urandom_range(0, 15) == 0) begin
      e.rd   = '0;
      e.data = $urandom;
      srcq[$urandom_range(0, NUM_SRC-1)].push_back(e);
    end
    if (g >= 0) begin
      void'(srcq[g].pop_front());
      wb_valid[g] = 1'b0;
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!wb_valid[s] && srcq[s].size() != 0 && $urandom_range(0, 3) != 0)
        set_wb(s, srcq[s][0].rd, srcq[s][0].data);
    end
    if (!allow_issue) begin
      issue_valid = 1'b0;
    end else if (!(issue_valid && !fired && $urandom_range(0, 3) != 0)) begin
      set_issue($urandom_range(0, 2) != 0, rand_reg(), rand_reg(), rand_reg());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int left;
    #1;
    do_reset();
    check("rst_wen", 32'(rf_wen), 32'd0);
    check("rst_a3", 32'(rf_a3), 32'd0);
    check("rst_wd", rf_wd, 32'd0);
    check("rst_pending", pending, 32'd0);

    // Single ALU write to x5
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1 check("single_issue_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    set_wb(SRC_ALU, 5'd5, 32'hDEADBEEF);
    #1 check("single_ready", 32'(wb_ready), 32'h1);
    check("single_pending_set", pending, 32'h0000_0020);
    tick();
    wb_valid = '0;
    #1 check("single_wen", 32'(rf_wen), 32'd1);
    check("single_a3", 32'(rf_a3), 32'd5);
    check("single_wd", rf_wd, 32'hDEADBEEF);
    tick();
    #1 check("single_wen_drop", 32'(rf_wen), 32'd0);
    check("single_pending_clr", pending, 32'd0);

    // Round-robin fairness from reset
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) set_wb(s, 5'd0, 32'h1000 + 32'(s));
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_all_valid", 32'(wb_ready), 32'd1 << (i % 3));
      tick();
    end
    wb_valid = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #1 check("rr_only_src2", 32'(wb_ready), 32'h4);
      tick();
    end
    wb_valid = '0;

    // RAW hazard on x7, released by LSU commit
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 5'd0, 5'd7, 5'd0);
    #1 check("raw_stall", 32'(issue_stall), 32'd1);
    tick();
    set_wb(SRC_LSU, 5'd7, 32'h1234_5678);
    #1 check("raw_lsu_ready", 32'(wb_ready), 32'h2);
    check("raw_stall_at_grant", 32'(issue_stall), 32'd1);
    tick();
    wb_valid = '0;
    #1 check("raw_commit_a3", 32'(rf_a3), 32'd7);
    check("raw_stall_at_commit", 32'(issue_stall), 32'd1);
    tick();
    #1 check("raw_release", 32'(issue_stall), 32'd0);
    issue_valid = 1'b0;
    tick();

    // WAW hazard on x9, released by MDU commit
    set_issue(1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    #1 check("waw_stall", 32'(issue_stall), 32'd1);
    set_wb(SRC_MDU, 5'd9, 32'h0BAD_F00D);
    tick();
    wb_valid = '0;
    #1 check("waw_commit_wd", rf_wd, 32'h0BAD_F00D);
    check("waw_stall_at_commit", 32'(issue_stall), 32'd1);
    tick();
    #1 check("waw_release", 32'(issue_stall), 32'd0);
    issue_valid = 1'b0;
    tick();

    // x0 writeback and x0 operands
    set_wb(SRC_MDU, 5'd0, 32'hCAFE_0000);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_ready", 32'(wb_ready), 32'h4);
    check("x0_no_stall", 32'(issue_stall), 32'd0);
    tick();
    wb_valid = '0;
    issue_valid = 1'b0;
    #1 check("x0_no_wen", 32'(rf_wen), 32'd0);
    check("x0_pending", pending, 32'd0);
    tick();

    // Asynchronous reset with x3/x4 pending and a commit in flight
    set_issue(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    set_issue(1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    issue_valid = 1'b0;
    set_wb(SRC_ALU, 5'd3, 32'h3333_3333);
    #1 check("ar_pending", pending, 32'h0000_0018);
    tick();
    wb_valid = '0;
    #1 check("ar_wen_before", 32'(rf_wen), 32'd1);
    rst_n = 1'b0;
    #1 check("ar_wen_dropped", 32'(rf_wen), 32'd0);
    check("ar_pending_dropped", pending, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) set_wb(s, 5'd0, 32'h0);
    #1 check("ar_src0_first", 32'(wb_ready), 32'h1);
    tick();
    wb_valid = '0;
    tick();

    // Randomized traffic, then drain
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 400; c++) begin
      left = 0;
      for (int s = 0; s < NUM_SRC; s++) left += srcq[s].size();
      if (left == 0 && wb_valid == '0) break;
      rand_cycle(1'b0);
    end
    left = 0;
    for (int s = 0; s < NUM_SRC; s++) left += srcq[s].size();
    check("drain_left", 32'(left), 32'd0);
    repeat (2) tick();
    check("drain_pending", pending, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Sequences all writes into the 32x32 RISC-V register file, which has one write port, and guards its two read ports against RAW/WAW hazards. Multiple writeback sources (ALU, LSU, MUL/DIV) compete for the single write port through a round-robin arbiter with valid/ready handshakes. A 32-entry pending-write scoreboard, set at issue and cleared at commit, drives the decode-stage stall. Sits between decode/execute units and the register file write port (a3/wd/wen).

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
XLEN, 32, data width of write data
REG_AW, 5, register address width (32 registers)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode presents an instruction this cycle
issue_rd  input  REG_AW  destination register of issuing instruction (0 = no write)
issue_rs1  input  REG_AW  source register 1 (0 = unused)
issue_rs2  input  REG_AW  source register 2 (0 = unused)
issue_stall  output  1  combinational: instruction must not issue this cycle
wb_valid  input  NUM_SRC  per-source writeback request
wb_rd  input  NUM_SRC*REG_AW  per-source destination, packed, source i at [i*REG_AW +: REG_AW]
wb_data  input  NUM_SRC*XLEN  per-source data, packed likewise
wb_ready  output  NUM_SRC  combinational one-hot grant; transfer when valid&&ready
rf_a3  output  REG_AW  register file write address (registered)
rf_wd  output  XLEN  register file write data (registered)
rf_wen  output  1  register file write enable (registered)
pending  output  32  scoreboard bit vector, for debug/verification

Behaviour:
- Reset (async, rst_n low): rf_wen=0, rf_a3=0, rf_wd=0, pending=0, rr_ptr=NUM_SRC-1 (source 0 has highest priority first). wb_ready follows its combinational rule even while in reset.
- Arbitration: round-robin over wb_valid, starting at rr_ptr+1 mod NUM_SRC. Exactly one wb_ready high when any wb_valid is high, else all 0. Grants are not blocked by rf state: the write stage takes one write per cycle, so at most one grant per cycle. On a grant, rr_ptr <= granted index. With no request, rr_ptr holds.
- Sources hold wb_valid/wb_rd/wb_data stable until granted. A source may deassert only after its transfer.
- Write stage, 1 cycle latency: a grant in cycle t gives rf_wen=1, rf_a3=wb_rd, rf_wd=wb_data in cycle t+1. The register file writes at the end of t+1. No grant: rf_wen=0, rf_a3/rf_wd hold.
- x0 writeback: granted and consumed normally, but rf_wen stays 0 and the scoreboard is untouched.
- Scoreboard set: issue_valid && !issue_stall && issue_rd!=0 -> pending[issue_rd] <= 1.
- Scoreboard clear: rf_wen && rf_a3!=0 -> pending[rf_a3] <= 0, on the same edge the register file commits.
- issue_stall = issue_valid && (pending[issue_rs1] || pending[issue_rs2] || pending[issue_rd]). pending[0] is constantly 0. issue_stall=0 when issue_valid=0.
- Set and clear of the same index in one cycle cannot occur legally, because the pending rd stalls. If forced, set wins. The bench flags it as an assertion failure.
- Readers use the register file one cycle after the clear edge. There is no bypass, so a stalled reader releases in the cycle after the commit edge.
- Writeback to an rd that is not pending is legal and writes the register file. An assertion warns but logic proceeds.
- Reset mid-operation: all pending bits and any in-flight rf_wen are dropped. Upstream units flush on the same reset.

Decomposition:
- Shared package: REG_AW, XLEN, NUM_REGS=32, source index constants (SRC_ALU=0, SRC_LSU=1, SRC_MDU=2), and a wb_req_t struct {rd, data}.
- Sub-module rr_arbiter (parameterised N; req, ptr in, one-hot grant, grant index out) instantiated once. The scoreboard and write stage stay in the top.

Test Plan:
- Reset then single write: ALU wb_valid, rd=5, data=0xDEADBEEF at t -> wb_ready=001 at t; rf_wen=1, rf_a3=5, rf_wd=0xDEADBEEF at t+1; rf_wen=0 at t+2.
- Round-robin fairness: all three sources held valid for 6 cycles -> grants 0,1,2,0,1,2. Then only source 2 valid -> grant 2 every cycle.
- RAW stall: issue rd=7 (pending[7]=1). Next, issue rs1=7 -> stall=1 until LSU writeback of rd=7 commits. Stall drops in the cycle after rf_wen with rf_a3=7.
- WAW stall: pending[9]=1, issue rd=9 -> stall=1. Release after commit of x9.
- x0 handling: MDU writeback rd=0 -> wb_ready granted, rf_wen stays 0, pending unchanged. Issue rs1=0, rs2=0, rd=0 never stalls.
- Async reset mid-flight: pending={x3,x4}, grant in progress, rst_n low between edges -> rf_wen=0, pending=0 immediately. After release, source 0 has priority.
